seq_divider: RTL and testbench

Parametrised multi-cycle integer divider for the CPU's HI/LO datapath, the next generation of the single-mode 32-bit divide unit. Computes quotient and remainder of `dividend / divisor` by restoring division, retiring `BITS_PER_CYCLE` quotient bits per clock. Operands may be signed or unsigned per operation. Uses a start/busy/done handshake and flags divide-by-zero without running the iteration.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 33 +++
 rtl/seq_divider.sv | 169 ++++++++++++++++
 tb/tb_seq_divider.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the sequential divider.
//   div_state_t : FSM state encoding (IDLE, CALC, FIX)
//   MAX_WIDTH   : widest operand the abs_val helper handles
//   cnt_width() : width of the iteration counter for a WIDTH/BITS_PER_CYCLE pair
//   abs_val()   : conditional two's-complement negate
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // abs_val works on a fixed-width container; callers zero-extend into it
    // and truncate the result back to their own width.
    localparam int MAX_WIDTH = 64;

    // The counter must hold WIDTH/BITS_PER_CYCLE itself, hence the +1.
    function automatic int cnt_width(input int width, input int bits_per_cycle);
        return $clog2(width / bits_per_cycle + 1);
    endfunction

    // Truncating the negated container back to the caller's width gives the
    // correct two's-complement magnitude, including most-negative mapping to
    // its own bit pattern.
    function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 negate);
        return negate ? (~value + 64'd1) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_in  : partial remainder entering the step (WIDTH+1 bits)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor magnitude
//   rem_out : partial remainder after the conditional subtract
//   q_bit   : resolved quotient bit
// ---------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // rem_in is always below the divisor, so its top bit is normally clear.
    // If it were set, the shifted value would certainly exceed the divisor,
    // so it forces the subtract.
    always_comb begin
        shifted = {rem_in[WIDTH-1:0], bit_in};
        q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider, signed or unsigned per operation, retiring
// BITS_PER_CYCLE quotient bits per clock.
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   start               : launch request, honoured only in IDLE
//   is_signed           : two's-complement divide when set, sampled with start
//   dividend, divisor   : operands, sampled with start
//   busy                : high from the cycle after acceptance through done
//   done                : one-cycle pulse, results valid from this cycle on
//   div_zero            : divisor was zero, held until the next done
//   quotient, remainder : results, held until the next done
// WIDTH must not exceed div_pkg::MAX_WIDTH.
// ---------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);

    div_state_t state;
    div_state_t state_next;
    logic       accept;

    // dvd_reg starts as the dividend magnitude; as its bits shift out of the
    // top, quotient bits shift in at the bottom, so after the last step it
    // holds the unsigned quotient.
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH:0]   rem_reg;
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             zero_reg;

    logic [WIDTH:0]          rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [WIDTH-1:0]        dvd_next;

    // Chain of restoring steps evaluated in one cycle; step k consumes the
    // k-th dividend bit from the top and produces the k-th quotient bit.
    assign rem_chain[0] = rem_reg;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        div_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .rem_in  (rem_chain[k]),
            .bit_in  (dvd_reg[WIDTH-1-k]),
            .divisor (dvs_reg),
            .rem_out (rem_chain[k+1]),
            .q_bit   (q_bits[BITS_PER_CYCLE-1-k])
        );
    end

    if (BITS_PER_CYCLE == WIDTH) begin : g_shift_all
        assign dvd_next = q_bits;
    end else begin : g_shift_part
        assign dvd_next = {dvd_reg[WIDTH-1-BITS_PER_CYCLE:0], q_bits};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero divisor skips the iteration and goes straight
    // to FIX, which then reports the flag. The counter is compared against 1
    // because it reaches 0 on the same edge that enters FIX.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers. busy covers every non-IDLE cycle plus
    // the done cycle, which is spent back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            rem_reg   <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            busy <= (state != IDLE) || accept;
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_reg  <= WIDTH'(abs_val(MAX_WIDTH'(dividend),
                                                   is_signed & dividend[WIDTH-1]));
                        dvs_reg  <= WIDTH'(abs_val(MAX_WIDTH'(divisor),
                                                   is_signed & divisor[WIDTH-1]));
                        q_neg    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg    <= is_signed & dividend[WIDTH-1];
                        zero_reg <= (divisor == '0);
                        rem_reg  <= '0;
                        cnt      <= CNT_W'(STEPS);
                    end
                end
                CALC: begin
                    rem_reg <= rem_chain[BITS_PER_CYCLE];
                    dvd_reg <= dvd_next;
                    cnt     <= cnt - CNT_W'(1);
                end
                FIX: begin
                    if (zero_reg) begin
                        quotient  <= '0;
                        remainder <= '0;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= q_neg ? -dvd_reg : dvd_reg;
                        remainder <= r_neg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider. Two instances: the default 32-bit,
// one-bit-per-cycle unit (dut A) and a 16-bit, four-bits-per-cycle unit
// (dut B). Expected results are queued when an operation is launched and
// popped when the matching done pulse appears.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        start_a, sgn_a;
    logic [31:0] dvd_a, dvs_a;
    logic        busy_a, done_a, dz_a;
    logic [31:0] q_a, r_a;

    logic        start_b, sgn_b;
    logic [15:0] dvd_b, dvs_b;
    logic        busy_b, done_b, dz_b;
    logic [15:0] q_b, r_b;

    seq_divider #(
        .WIDTH          (32),
        .BITS_PER_CYCLE (1)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
        .is_signed (sgn_a),
        .dividend  (dvd_a),
        .divisor   (dvs_a),
        .busy      (busy_a),
        .done      (done_a),
        .div_zero  (dz_a),
        .quotient  (q_a),
        .remainder (r_a)
    );

    seq_divider #(
        .WIDTH          (16),
        .BITS_PER_CYCLE (4)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .is_signed (sgn_b),
        .dividend  (dvd_b),
        .divisor   (dvs_b),
        .busy      (busy_b),
        .done      (done_b),
        .div_zero  (dz_b),
        .quotient  (q_b),
        .remainder (r_b)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          t_acc;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    // Reference division in 64-bit signed arithmetic, then truncated to w
    // bits; most-negative / -1 wraps naturally through the truncation.
    function automatic void refModel(input int w, input bit sgn,
                                     input logic [31:0] a_in, input logic [31:0] b_in,
                                     output logic [31:0] q, output logic [31:0] r,
                                     output logic dz);
        logic [63:0] mask;
        longint      sa, sb, qq, rr;
        mask = (64'd1 << w) - 64'd1;
        sa   = longint'({32'd0, a_in} & mask);
        sb   = longint'({32'd0, b_in} & mask);
        if (sgn) begin
            if (sa[w-1]) sa = sa - longint'(64'd1 << w);
            if (sb[w-1]) sb = sb - longint'(64'd1 << w);
        end
        if (sb == 0) begin
            q  = 32'd0;
            r  = 32'd0;
            dz = 1'b1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q  = 32'(qq & longint'(mask));
            r  = 32'(rr & longint'(mask));
            dz = 1'b0;
        end
    endfunction

    // Waits for the selected unit to go idle, launches one operation and
    // queues its expected result and latency.
    task automatic applyStimulus(input int sel, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eq, input logic [31:0] er,
                                 input logic edz);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel == 0 ? busy_a : busy_b) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("idle_wait_timeout", 32'd1, 32'd0);
        e.q     = eq;
        e.r     = er;
        e.dz    = edz;
        e.lat   = edz ? 1 : (sel == 0 ? 33 : 5);
        e.t_acc = cycle + 1;
        if (sel == 0) begin
            start_a = 1'b1;
            sgn_a   = sgn;
            dvd_a   = a;
            dvs_a   = b;
            exp_a.push_back(e);
        end else begin
            start_b = 1'b1;
            sgn_b   = sgn;
            dvd_b   = a[15:0];
            dvs_b   = b[15:0];
            exp_b.push_back(e);
        end
        @(negedge clk);
        if (sel == 0) begin
            start_a = 1'b0;
            dvd_a   = $urandom;
            dvs_a   = $urandom;
            checkOutput("busy_on_a", {31'd0, busy_a}, 32'd1);
        end else begin
            start_b = 1'b0;
            dvd_b   = 16'($urandom);
            dvs_b   = 16'($urandom);
            checkOutput("busy_on_b", {31'd0, busy_b}, 32'd1);
        end
    endtask

    task automatic applyModel(input int sel, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        edz;
        refModel(sel == 0 ? 32 : 16, sgn, a, b, eq, er, edz);
        applyStimulus(sel, sgn, a, b, eq, er, edz);
    endtask

    task automatic scoreDone(input int sel, input logic [31:0] q, input logic [31:0] r, input logic dz);
        exp_t e;
        if (sel == 0) begin
            if (exp_a.size() == 0) begin
                checkOutput("extra_done_a", 32'd1, 32'd0);
                return;
            end
            e = exp_a.pop_front();
        end else begin
            if (exp_b.size() == 0) begin
                checkOutput("extra_done_b", 32'd1, 32'd0);
                return;
            end
            e = exp_b.pop_front();
        end
        checkOutput(sel == 0 ? "quotient_a"  : "quotient_b",  q, e.q);
        checkOutput(sel == 0 ? "remainder_a" : "remainder_b", r, e.r);
        checkOutput(sel == 0 ? "div_zero_a"  : "div_zero_b",  {31'd0, dz}, {31'd0, e.dz});
        checkOutput(sel == 0 ? "latency_a"   : "latency_b",   32'(cycle - e.t_acc), 32'(e.lat));
    endtask

    // Done monitors: score each pulse and require it to last one cycle.
    logic pulse_a = 1'b0;
    logic pulse_b = 1'b0;

    always @(negedge clk) begin
        if (pulse_a) checkOutput("done_pulse_a", {31'd0, done_a}, 32'd0);
        pulse_a <= done_a;
        if (done_a) scoreDone(0, q_a, r_a, dz_a);
    end

    always @(negedge clk) begin
        if (pulse_b) checkOutput("done_pulse_b", {31'd0, done_b}, 32'd0);
        pulse_b <= done_b;
        if (done_b) scoreDone(1, {16'd0, q_b}, {16'd0, r_b}, dz_b);
    end

    task automatic waitDrain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_a.size() == 0 && exp_b.size() == 0 && !busy_a && !busy_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_busy_a", {31'd0, busy_a}, 32'd0);
        checkOutput("rst_done_a", {31'd0, done_a}, 32'd0);
        checkOutput("rst_dz_a",   {31'd0, dz_a},   32'd0);
        checkOutput("rst_q_a",    q_a,             32'd0);
        checkOutput("rst_r_a",    r_a,             32'd0);
        checkOutput("rst_busy_b", {31'd0, busy_b}, 32'd0);
        checkOutput("rst_q_b",    {16'd0, q_b},    32'd0);
        checkOutput("rst_r_b",    {16'd0, r_b},    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bit          sgn;
        int          sel;

        reset   = 1'b1;
        start_a = 1'b0; sgn_a = 1'b0; dvd_a = '0; dvs_a = '0;
        start_b = 1'b0; sgn_b = 1'b0; dvd_b = '0; dvs_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState();
        reset = 1'b0;

        $display("[TB] directed operations, 32-bit unit");
        applyStimulus(0, 1'b1, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0);
        applyStimulus(0, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
        applyStimulus(0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
        applyStimulus(0, 1'b0, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15,         1'b0);
        applyStimulus(0, 1'b1, 32'd123,        32'd0,          32'd0,          32'd0,          1'b1);
        applyStimulus(0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        applyStimulus(0, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0);

        // A start while busy must be dropped without disturbing the op.
        applyStimulus(0, 1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0);
        repeat (4) @(negedge clk);
        start_a = 1'b1; sgn_a = 1'b1; dvd_a = 32'd5; dvs_a = 32'd1;
        @(negedge clk);
        start_a = 1'b0;
        checkOutput("busy_hold_a", {31'd0, busy_a}, 32'd1);
        waitDrain();

        $display("[TB] directed operations, 16-bit unit");
        applyStimulus(1, 1'b1, 32'h0000FF9C,   32'd7,          32'h0000FFF2,   32'h0000FFFE,   1'b0);
        applyStimulus(1, 1'b0, 32'h0000FFFF,   32'd0,          32'd0,          32'd0,          1'b1);
        applyStimulus(1, 1'b1, 32'h00008000,   32'h0000FFFF,   32'h00008000,   32'd0,          1'b0);
        applyStimulus(1, 1'b0, 32'h0000FFFF,   32'd16,         32'h00000FFF,   32'd15,         1'b0);
        waitDrain();

        $display("[TB] randomized operations against the reference model");
        for (int i = 0; i < 40; i++) begin
            sel = i % 2;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'd0;
                default: b = $urandom;
            endcase
            if (sel == 1) begin
                a = a & 32'h0000FFFF;
                b = b & 32'h0000FFFF;
            end
            applyModel(sel, sgn, a, b);
        end
        waitDrain();

        $display("[TB] reset during an operation");
        applyStimulus(0, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
        waitDrain();
        applyStimulus(0, 1'b1, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetState();
        exp_a.delete();
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("no_done_after_abort", {31'd0, busy_a}, 32'd0);

        // Reset and start together: reset wins, nothing is launched.
        reset   = 1'b1;
        start_a = 1'b1; sgn_a = 1'b0; dvd_a = 32'd9; dvs_a = 32'd2;
        @(negedge clk);
        checkOutput("rst_start_busy_a", {31'd0, busy_a}, 32'd0);
        reset   = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        checkOutput("rst_start_idle_a", {31'd0, busy_a}, 32'd0);

        // A fresh operation after the abort completes normally.
        applyStimulus(0, 1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
